// File: rtl/mul_seq.sv
// Multi-cycle sequencer and accumulator for the ARMv4 multiply / multiply-long family.
// Steers the external multiply unit through capture, low-half and high-half read-back,
// adds the latched accumulator words (carry rippled from low to high) and issues
// register-file write strobes plus N/Z flag updates.
module mul_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        L,
    input  logic        U_In,
    input  logic        A,
    input  logic        S,
    input  logic [31:0] Acc_Lo,
    input  logic [31:0] Acc_Hi,
    input  logic [31:0] Prod,
    output logic        LD_MUL,
    output logic        MUL_HiLo,
    output logic        U,
    output logic [31:0] Result,
    output logic        WR_Lo,
    output logic        WR_Hi,
    output logic        FLAG_WE,
    output logic        N,
    output logic        Z,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StLo,
        StHi,
        StDone
    } state_e;

    state_e      r_state;
    logic        r_l;
    logic        r_u;
    logic        r_a;
    logic        r_s;
    logic [31:0] r_acc_lo;
    logic [31:0] r_acc_hi;
    logic        r_carry;
    logic        r_lz;
    logic [31:0] r_result;
    logic        r_wr_lo;
    logic        r_wr_hi;
    logic        r_flag_we;
    logic        r_n;
    logic        r_z;
    logic        r_done;

    logic [32:0] w_sum_lo;
    logic [31:0] w_sum_hi;

    // Accumulate adders; carry out of the low word feeds the high word.
    always_comb begin
        w_sum_lo = {1'b0, Prod} + {1'b0, (r_a ? r_acc_lo : 32'h0)};
        w_sum_hi = Prod + (r_a ? r_acc_hi : 32'h0) + {31'h0, r_carry};
    end

    // Sequencer FSM with registered result, strobes and flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= StIdle;
            r_l       <= 1'b0;
            r_u       <= 1'b0;
            r_a       <= 1'b0;
            r_s       <= 1'b0;
            r_acc_lo  <= 32'h0;
            r_acc_hi  <= 32'h0;
            r_carry   <= 1'b0;
            r_lz      <= 1'b0;
            r_result  <= 32'h0;
            r_wr_lo   <= 1'b0;
            r_wr_hi   <= 1'b0;
            r_flag_we <= 1'b0;
            r_n       <= 1'b0;
            r_z       <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_wr_lo   <= 1'b0;
            r_wr_hi   <= 1'b0;
            r_flag_we <= 1'b0;
            r_done    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (START) begin
                        r_l      <= L;
                        r_u      <= U_In;
                        r_a      <= A;
                        r_s      <= S;
                        r_acc_lo <= Acc_Lo;
                        r_acc_hi <= Acc_Hi;
                        r_state  <= StMul;
                    end
                end
                StMul: begin
                    r_state <= StLo;
                end
                StLo: begin
                    r_result <= w_sum_lo[31:0];
                    r_carry  <= w_sum_lo[32];
                    r_lz     <= (w_sum_lo[31:0] == 32'h0);
                    r_wr_lo  <= 1'b1;
                    if (r_l) begin
                        r_state <= StHi;
                    end else begin
                        // Short form: low-word carry is discarded, flags come from low word.
                        r_state   <= StDone;
                        r_done    <= 1'b1;
                        r_flag_we <= r_s;
                        r_n       <= w_sum_lo[31];
                        r_z       <= (w_sum_lo[31:0] == 32'h0);
                    end
                end
                StHi: begin
                    r_result  <= w_sum_hi;
                    r_wr_hi   <= 1'b1;
                    r_done    <= 1'b1;
                    r_flag_we <= r_s;
                    r_n       <= w_sum_hi[31];
                    r_z       <= r_lz & (w_sum_hi == 32'h0);
                    r_state   <= StDone;
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign LD_MUL   = (r_state == StMul);
    assign MUL_HiLo = (r_state == StHi);
    assign BUSY     = (r_state != StIdle);
    assign U        = (r_state != StIdle) & r_u;
    assign Result   = r_result;
    assign WR_Lo    = r_wr_lo;
    assign WR_Hi    = r_wr_hi;
    assign FLAG_WE  = r_flag_we;
    assign N        = r_n;
    assign Z        = r_z;
    assign DONE     = r_done;

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer and accumulator for the ARMv4 multiply and multiply-long families (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL). It sits directly downstream of the multiply unit and controls it.
- Drives the unit's `LD_MUL`, `MUL_HiLo` and `U` controls.
- Reads the product halves back from the B bus.
- Adds the latched accumulator operands, with carry propagated from the low word into the high word.
- Issues register-file write strobes and N/Z flag updates.

## Interface
Parameters: none.

Ports:
- `CLK` in 1 — single clock; all state updates on rising edge.
- `RST` in 1 — synchronous, active-high reset.
- `START` in 1 — begin an operation; sampled only in IDLE.
- `L` in 1 — IR[23]: 1 = long (64-bit result).
- `U_In` in 1 — IR[22]: 1 = signed (multiply-unit convention).
- `A` in 1 — IR[21]: 1 = accumulate.
- `S` in 1 — IR[20]: 1 = update flags.
- `Acc_Lo` in 32 — Rn (MLA) or RdLo (long accumulate); sampled at START.
- `Acc_Hi` in 32 — RdHi (long accumulate); sampled at START.
- `Prod` in 32 — multiply unit output from the B bus.
- `LD_MUL` out 1 — to the multiply unit: capture product.
- `MUL_HiLo` out 1 — to the multiply unit: 1 = high half on `Prod`.
- `U` out 1 — to the multiply unit: latched `U_In`.
- `Result` out 32 — registered result word.
- `WR_Lo` out 1 — one-cycle strobe: write `Result` to Rd (short) or RdLo (long).
- `WR_Hi` out 1 — one-cycle strobe: write `Result` to RdHi.
- `FLAG_WE` out 1 — one-cycle strobe: write N and Z.
- `N` out 1 — negative flag value.
- `Z` out 1 — zero flag value.
- `BUSY` out 1 — high from the cycle after START up to and including the DONE cycle.
- `DONE` out 1 — one-cycle completion pulse.

## Operation
- States: IDLE, MUL, LO, HI, DONE.
- IDLE:
  - `START`=1 latches `L`, `U_In`, `A`, `S`, `Acc_Lo`, `Acc_Hi`, then moves to MUL.
  - `START`=0 stays in IDLE.
- MUL:
  - `LD_MUL`=1 for exactly this cycle.
  - The B and C buses must carry Rm and Rs during this cycle; this block does not drive them.
  - Next state: LO.
- LO:
  - `MUL_HiLo`=0.
  - Computes sum_lo = `Prod` + (A ? Acc_Lo : 0) as 33 bits.
  - Registers bit 32 as carry (carry is 0 when A=0).
  - Registers sum_lo[31:0] into `Result`, sets the next-cycle `WR_Lo`, and sets the low-zero flag lz = (sum_lo[31:0]==0).
  - Next state: HI if L=1, else DONE.
- HI:
  - `MUL_HiLo`=1.
  - Computes sum_hi = `Prod` + (A ? Acc_Hi : 0) + carry, mod 2^32.
  - Registers sum_hi into `Result` and sets the next-cycle `WR_Hi`.
  - Next state: DONE.
- DONE:
  - `DONE`=1 and `FLAG_WE`=S.
  - Short: N = Result[31], Z = lz.
  - Long: N = sum_hi[31], Z = lz & (sum_hi==0), i.e. all 64 bits zero.
  - C and V are never driven.
  - Next state: IDLE.
- `U` holds the latched value from the MUL state through DONE; in IDLE it is 0.
- `START` while not in IDLE is ignored; there is no queueing.
- `Acc_Lo` and `Acc_Hi` may change after the START cycle without affecting the result.

## Timing
- START is accepted in cycle t.
- Short operation:
  - t+1: MUL.
  - t+2: LO.
  - t+3: DONE, with `WR_Lo`=1 and `Result`=low.
  - Latency: 3 cycles.
- Long operation:
  - t+1: MUL.
  - t+2: LO.
  - t+3: HI, with `WR_Lo`=1 and `Result`=low.
  - t+4: DONE, with `WR_Hi`=1 and `Result`=high.
  - Latency: 4 cycles.
- Back-to-back: a new START is accepted in the cycle after DONE, i.e. at the earliest in t+4 for short and t+5 for long.
- `LD_MUL`, `MUL_HiLo` and `BUSY` are decoded from state. `Result`, `WR_*`, `FLAG_WE`, `N`, `Z` and `DONE` are registered.
- Reset, including mid-operation: on the edge with `RST`=1, state goes to IDLE and every output is 0 from the next cycle. Pending strobes are dropped and no write or flag strobe is emitted for the aborted operation. `RST` overrides `START`.

## Test plan
- MUL, U_In=0, L=0, A=0, S=1, Rm=7, Rs=6 → `WR_Lo` at t+3, `Result`=0x0000002A, `FLAG_WE`=1, N=0, Z=0, `DONE` at t+3.
- MLA, Rm=0xFFFFFFFF, Rs=1, Acc_Lo=1, S=1 → `Result`=0x00000000, Z=1, N=0; carry out of the low word is discarded for the short form.
- UMULL, U_In=0, Rm=0xFFFFFFFF, Rs=2 → t+3: `WR_Lo`, `Result`=0xFFFFFFFE; t+4: `WR_Hi`, `Result`=0x00000001.
- SMLAL, U_In=1, Rm=0xFFFFFFFF, Rs=1, Acc_Hi=0, Acc_Lo=1, S=1 → low word 0x00000000 with carry 1, high word 0x00000000; Z=1, N=0. Repeat with Acc_Lo=3, Rs=2 → low 0x00000001, high 0x00000000, Z=0.
- Assert `START` pulses at t+1 and t+2 of a long operation, and change `Acc_Hi` at t+1 → only one operation runs and the result uses the `Acc_Hi` value from cycle t.
- Assert `RST` at t+3 of a long operation → no `WR_Hi`, `DONE` or `FLAG_WE`; all outputs 0 at t+4; a fresh START at t+4 completes normally.
